// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and operation-decode helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One multiply/divide iteration on magnitudes: conditional add + right shift for
// multiply, left shift + trial subtract/restore for divide, through one adder.
module muldiv_step #(
    parameter int unsigned N = 32
) (
    input  logic         i_div,
    input  logic [N-1:0] i_hi,
    input  logic [N-1:0] i_lo,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_hi_c,
    output logic [N-1:0] o_lo_c
);

    logic [N:0]   w_shift;
    logic [N:0]   w_op_a;
    logic [N:0]   w_op_b;
    logic         w_cin;
    logic [N+1:0] w_sum;

    always_comb begin
        w_shift = {i_hi, i_lo[N-1]};
        w_op_a  = {1'b0, i_hi};
        w_op_b  = i_lo[0] ? {1'b0, i_b} : '0;
        w_cin   = 1'b0;
        if (i_div) begin
            w_op_a = w_shift;
            w_op_b = ~{1'b0, i_b};
            w_cin  = 1'b1;
        end
        // For divide, bit N+1 is the no-borrow flag of shifted remainder minus divisor
        w_sum = {1'b0, w_op_a} + {1'b0, w_op_b} + (N+2)'(w_cin);

        o_hi_c = w_sum[N:1];
        o_lo_c = {w_sum[0], i_lo[N-1:1]};
        if (i_div) begin
            if (w_sum[N+1]) begin
                o_hi_c = w_sum[N-1:0];
                o_lo_c = {i_lo[N-2:0], 1'b1};
            end else begin
                o_hi_c = w_shift[N-1:0];
                o_lo_c = {i_lo[N-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle. Defining
// MULDIV_EARLY_OUT_EN sends zero-operand multiplies and zero-dividend divides down the fast path.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] rs1Data,
    input  logic [N-1:0] rs2Data,
    input  logic [4:0]   rdAddress,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [4:0]   resultAddress
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, (N-1)'(0)};

    state_e        r_state;
    state_e        w_state_nxt;
    logic [2:0]    r_f3;
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_b;
    logic          r_neg;
    logic [CW-1:0] r_cnt;

    logic           w_sign_a, w_sign_b, w_is_div, w_is_rem;
    logic           w_div_zero, w_ovf, w_early, w_fast;
    logic [N-1:0]   w_mag_a, w_mag_b, w_fast_res;
    logic [N-1:0]   w_step_hi, w_step_lo;
    logic [N-1:0]   w_div_raw, w_div_fix, w_fix_res;
    logic [2*N-1:0] w_prod_fix;

    // Accept-time decode: magnitudes and fast-path detection
    always_comb begin
        w_is_div   = is_div(funct3);
        w_is_rem   = is_rem(funct3);
        w_sign_a   = is_signed_a(funct3) & rs1Data[N-1];
        w_sign_b   = is_signed_b(funct3) & rs2Data[N-1];
        w_mag_a    = w_sign_a ? -rs1Data : rs1Data;
        w_mag_b    = w_sign_b ? -rs2Data : rs2Data;
        w_div_zero = w_is_div & (rs2Data == '0);
        w_ovf      = w_is_div & is_signed_b(funct3) & (rs1Data == MIN_NEG) & (rs2Data == '1);
`ifdef MULDIV_EARLY_OUT_EN
        w_early    = w_is_div ? ((rs1Data == '0) && (rs2Data != '0))
                              : ((rs1Data == '0) || (rs2Data == '0));
`else
        w_early    = 1'b0;
`endif
        w_fast     = w_div_zero | w_ovf | w_early;
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = w_is_rem ? rs1Data : '1;
        end else if (w_ovf) begin
            w_fast_res = w_is_rem ? '0 : rs1Data;
        end
    end

    muldiv_step #(.N(N)) u_step (
        .i_div  (is_div(r_f3)),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .i_b    (r_b),
        .o_hi_c (w_step_hi),
        .o_lo_c (w_step_lo)
    );

    // Sign correction of the finished magnitude result
    always_comb begin
        w_prod_fix = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_div_raw  = is_rem(r_f3) ? r_hi : r_lo;
        w_div_fix  = r_neg ? -w_div_raw : w_div_raw;
        if (is_div(r_f3)) begin
            w_fix_res = w_div_fix;
        end else if (r_f3 == F3_MUL) begin
            w_fix_res = w_prod_fix[N-1:0];
        end else begin
            w_fix_res = w_prod_fix[2*N-1:N];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_fast ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == '0) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Multiply keeps the multiplier in r_lo and the multiplicand in r_b; divide keeps dividend/divisor
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            resultAddress <= '0;
            r_f3          <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_b           <= '0;
            r_neg         <= 1'b0;
            r_cnt         <= '0;
        end else begin
            busy <= (r_state != ST_IDLE);
            done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_f3          <= funct3;
                        resultAddress <= rdAddress;
                        r_cnt         <= CW'(N-1);
                        r_hi          <= '0;
                        r_neg         <= w_is_rem ? w_sign_a : (w_sign_a ^ w_sign_b);
                        r_lo          <= w_is_div ? w_mag_a : w_mag_b;
                        r_b           <= w_is_div ? w_mag_b : w_mag_a;
                        if (w_fast) begin
                            result <= w_fast_res;
                        end
                    end
                end
                ST_CALC: begin
                    r_hi <= w_step_hi;
                    r_lo <= w_step_lo;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_FIX: result <= w_fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, random ops, continuous start and
// mid-operation reset, checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int L = 80;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [4:0]  rdAddress;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  resultAddress;

    int checks = 0;
    int errors = 0;

    logic [2:0]  bf3 [L];
    logic [31:0] ba  [L];
    logic [31:0] bb  [L];
    logic [4:0]  brd [L];

    muldiv_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .funct3        (funct3),
        .rs1Data       (rs1Data),
        .rs2Data       (rs2Data),
        .rdAddress     (rdAddress),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .resultAddress (resultAddress)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        logic dv, fast;
        dv   = f3[2];
        fast = (dv && b == 0) ||
               ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
        if (dv) fast = fast || (a == 0 && b != 0);
        else    fast = fast || a == 0 || b == 0;
`endif
        return fast ? 1 : 34;
    endfunction

    // One op from an idle unit: latency, busy window, result, address, done falling
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int seen;
        int lat;
        logic busy_ok;
        logic [31:0] er;
        lat = exp_lat(f3, a, b);
        er  = ref_res(f3, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1Data = a; rs2Data = b; rdAddress = rd;
        @(posedge clk);
        #1;
        start = 1'b0; rs1Data = $urandom; rs2Data = $urandom; rdAddress = ~rd;
        seen = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) seen = c;
        end
        check({tag, "_latency"}, 64'(seen), 64'(lat));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_rd"}, 64'(resultAddress), 64'(rd));
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, 64'(done), 64'd0);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int exp_done;
        int nacc;
        rst = 1'b0; start = 1'b0; funct3 = '0; rs1Data = '0; rs2Data = '0; rdAddress = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_rd", 64'(resultAddress), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        check("mul_7_m3_value", 64'(result), 64'hFFFF_FFEB);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        check("mulh_min_value", 64'(result), 64'h4000_0000);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        check("mulhu_max_value", 64'(result), 64'hFFFF_FFFE);
        run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        check("mulhsu_value", 64'(result), 64'hFFFF_FFFF);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        check("div_m7_2_value", 64'(result), 64'hFFFF_FFFD);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        check("rem_m7_2_value", 64'(result), 64'hFFFF_FFFF);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd7);
        check("divu_value", 64'(result), 64'd14);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd8);
        check("remu_value", 64'(result), 64'd2);
        run_op("div_5_0", 3'd4, 32'd5, 32'd0, 5'd9);
        check("div_5_0_value", 64'(result), 64'hFFFF_FFFF);
        run_op("remu_5_0", 3'd7, 32'd5, 32'd0, 5'd10);
        check("remu_5_0_value", 64'(result), 64'd5);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        check("div_ovf_value", 64'(result), 64'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        check("rem_ovf_value", 64'(result), 64'd0);
        run_op("mul_0_9", 3'd0, 32'd0, 32'd9, 5'd0);
        check("mul_0_9_value", 64'(result), 64'd0);
        run_op("div_0_3", 3'd4, 32'd0, 32'd3, 5'd13);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            run_op("rand", 3'($urandom_range(0, 7)), a, b, 5'($urandom));
        end

        // start held high with fresh operands every cycle
        for (int k = 0; k < L; k++) begin
            bf3[k] = 3'($urandom_range(0, 7));
            ba[k]  = 32'($urandom);
            bb[k]  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            brd[k] = 5'($urandom);
        end
        exp_done = exp_lat(bf3[0], ba[0], bb[0]);
        nacc = 0;
        for (int k = 0; k < L + 40; k++) begin
            @(negedge clk);
            start = (k < L);
            if (k < L) begin
                funct3 = bf3[k]; rs1Data = ba[k]; rs2Data = bb[k]; rdAddress = brd[k];
            end
            @(posedge clk);
            #1;
            check("b2b_done", 64'(done), 64'(k == exp_done));
            if (k == exp_done) begin
                check("b2b_result", 64'(result), 64'(ref_res(bf3[nacc], ba[nacc], bb[nacc])));
                check("b2b_rd", 64'(resultAddress), 64'(brd[nacc]));
                nacc = k + 1;
                exp_done = (nacc < L) ? nacc + exp_lat(bf3[nacc], ba[nacc], bb[nacc]) : -1;
            end
        end
        start = 1'b0;

        // reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1Data = 32'd1000; rs2Data = 32'd3; rdAddress = 5'd17;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        check("rst_mid_rd", 64'(resultAddress), 64'd0);
        begin
            logic any_done;
            any_done = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                #1;
                if (c == 2) rst = 1'b1;
                if (done !== 1'b0) any_done = 1'b1;
            end
            check("rst_no_done", 64'(any_done), 64'd0);
        end
        run_op("mul_3_4_after_rst", 3'd0, 32'd3, 32'd4, 5'd21);
        check("mul_3_4_value", 64'(result), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
